branch_predictor: RTL
=====================

# branch_predictor

Dynamic branch predictor and mispredict resolver for the RV32I 5-stage pipeline. In IF it looks up the fetch PC in a direct-mapped branch target buffer (BTB) and predicts taken/not-taken with a target address. In EX it takes the resolved outcome from the branch comparator and does three things: trains the table, flags a mispredict, and supplies the redirect PC.

## Interface
Parameters:
- ENTRIES, 16, number of BTB rows; power of two, minimum 2.
- IDX_W, $clog2(ENTRIES), index width; the index is pc[IDX_W+1:2].

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- pc_f  in  32  fetch-stage PC.
- pred_taken_f  out  1  prediction for pc_f.
- pred_target_f  out  32  predicted target; 0 when pred_taken_f=0.
- upd_en  in  1  EX-stage instruction is a conditional branch or JAL.
- upd_pc  in  32  PC of the EX-stage instruction.
- upd_taken  in  1  resolved outcome from the branch comparator (1 for JAL).
- upd_target  in  32  resolved target address.
- upd_pred_taken  in  1  prediction carried down the pipe with the instruction.
- upd_pred_target  in  32  predicted target carried down the pipe.
- mispredict  out  1  flush IF/ID and ID/EX.
- redirect_pc  out  32  next fetch PC when mispredict=1.

## Operation
- Row contents: valid (1 bit), tag = pc[31:IDX_W+2], target (32 bits), ctr (2-bit saturating counter: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T).
- Lookup (combinational):
  - hit = valid & (tag == pc_f[31:IDX_W+2]).
  - pred_taken_f = hit & ctr[1].
  - pred_target_f = pred_taken_f ? target : 0.
- Update, on a clock edge with upd_en=1, for the row indexed by upd_pc:
  - On a hit, taken: ctr increments, saturating at 11, and target is written with upd_target.
  - On a hit, not taken: ctr decrements, saturating at 00, and target is unchanged.
  - On a miss, taken: the row is allocated and any previous occupant is overwritten. The row gets valid=1, the new tag, target=upd_target and ctr=10.
  - On a miss, not taken: no state change.
- upd_en=0: no state change, and mispredict=0.
- Mispredict (combinational): mispredict = upd_en & ((upd_taken != upd_pred_taken) | (upd_taken & upd_pred_taken & (upd_target != upd_pred_target))).
- Redirect: redirect_pc = upd_taken ? upd_target : upd_pc + 32'd4, with wrap-around mod 2^32. It is driven at all times and only meaningful while mispredict=1.
- Reset: every row is cleared to valid=0, tag=0, target=0, ctr=01. Outputs during reset are pred_taken_f=0, pred_target_f=0, and mispredict=0 whenever upd_en=0.
- Reset asserted mid-operation clears the table immediately, without waiting for a clock edge. Any update on that edge is discarded.

## Timing
- Lookup latency is zero cycles (pure combinational from pc_f).
- An update is visible to lookups starting the cycle after the clk edge that samples upd_en=1.
- Simultaneous lookup and update of the same row in the same cycle: the lookup returns the pre-update contents. There is no bypass.
- mispredict and redirect_pc are combinational in the same cycle as the EX inputs. The pipeline registers them for its flush.
- The table is written at most once per cycle.

## Structure
- Shared package holds:
  - bp_ctr_t enum {STRONG_NT=2'b00, WEAK_NT=2'b01, WEAK_T=2'b10, STRONG_T=2'b11}.
  - The btb_row_t struct {valid, tag, target, ctr}.
  - A function ctr_next(bp_ctr_t, logic taken) implementing the saturating update.
- Table storage is a flip-flop array, not an inferred RAM. This is required for the asynchronous clear.
- No sub-module is required; the counter logic lives in the package function.

## Test plan
- Reset, then pc_f=0x100 -> pred_taken_f=0, pred_target_f=0.
- Update upd_pc=0x100, taken, target 0x80, upd_pred_taken=0 -> mispredict=1, redirect_pc=0x80. Next cycle pc_f=0x100 gives pred_taken_f=1, target 0x80.
- Train 0x100 taken three times, then not taken once -> pred_taken_f stays 1 (ctr 11→10). A second not-taken drops it to 0.
- Alias pc 0x140 (same index, different tag, ENTRIES=16) taken, target 0x20 -> row replaced; lookup of 0x100 misses and 0x140 hits with 0x20.
- Predicted taken to 0x80, resolved taken to 0x90 -> mispredict=1, redirect_pc=0x90. Resolved not taken at upd_pc=0xFFFFFFFC -> redirect_pc=0x00000000.
- Assert rst asynchronously between edges after training -> pred_taken_f drops to 0 with no clock edge. An update presented in the same cycle is not applied.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared types and helpers for the BTB-based dynamic branch predictor:
// counter encoding, table row layout and the saturating counter update.
package branch_predictor_pkg;

   typedef enum logic [1:0] {
      STRONG_NT = 2'b00,
      WEAK_NT   = 2'b01,
      WEAK_T    = 2'b10,
      STRONG_T  = 2'b11
   } bp_ctr_t;

   // Tag is held zero-extended to 32 bits so the row layout does not depend on ENTRIES.
   typedef struct packed {
      logic        valid;
      logic [31:0] tag;
      logic [31:0] target;
      bp_ctr_t     ctr;
   } btb_row_t;

   localparam btb_row_t ROW_RESET = '{valid: 1'b0, tag: 32'd0, target: 32'd0, ctr: WEAK_NT};

   function automatic bp_ctr_t ctr_next(input bp_ctr_t ctr, input logic taken);
      if (taken) begin
         return (ctr == STRONG_T) ? STRONG_T : bp_ctr_t'(ctr + 2'b01);
      end
      return (ctr == STRONG_NT) ? STRONG_NT : bp_ctr_t'(ctr - 2'b01);
   endfunction

   function automatic logic [31:0] tag_of(input logic [31:0] pc, input int idx_w);
      return pc >> (idx_w + 2);
   endfunction

endpackage

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters: combinational lookup in IF,
// training plus mispredict/redirect generation from the resolved EX branch.
module branch_predictor
   import branch_predictor_pkg::*;
#(
   parameter int ENTRIES = 16,
   parameter int IDX_W   = $clog2(ENTRIES)
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_f,
   output logic        pred_taken_f,
   output logic [31:0] pred_target_f,
   input  logic        upd_en,
   input  logic [31:0] upd_pc,
   input  logic        upd_taken,
   input  logic [31:0] upd_target,
   input  logic        upd_pred_taken,
   input  logic [31:0] upd_pred_target,
   output logic        mispredict,
   output logic [31:0] redirect_pc
);

   btb_row_t         btb_q [ENTRIES];
   btb_row_t         row_f;
   btb_row_t         upd_row;
   btb_row_t         row_d;
   logic [IDX_W-1:0] idx_f;
   logic [IDX_W-1:0] upd_idx;
   logic [31:0]      upd_tag;
   logic             hit_f;
   logic             upd_hit;
   logic             wr_en;

   assign idx_f         = pc_f[IDX_W+1:2];
   assign row_f         = btb_q[idx_f];
   assign hit_f         = row_f.valid && (row_f.tag == tag_of(pc_f, IDX_W));
   assign pred_taken_f  = hit_f && row_f.ctr[1];
   assign pred_target_f = pred_taken_f ? row_f.target : 32'd0;

   assign upd_idx = upd_pc[IDX_W+1:2];
   assign upd_tag = tag_of(upd_pc, IDX_W);
   assign upd_row = btb_q[upd_idx];
   assign upd_hit = upd_row.valid && (upd_row.tag == upd_tag);

   // NOTE: row_d and wr_en get defaults first so no path through the ifs leaves them unassigned (no latch).
   always_comb begin
      row_d = upd_row;
      wr_en = 1'b0;
      if (upd_en) begin
         if (upd_hit) begin
            wr_en     = 1'b1;
            row_d.ctr = ctr_next(upd_row.ctr, upd_taken);
            if (upd_taken) begin
               row_d.target = upd_target;
            end
         end else if (upd_taken) begin
            wr_en = 1'b1;
            row_d = '{valid: 1'b1, tag: upd_tag, target: upd_target, ctr: WEAK_T};
         end
      end
   end

   // NOTE: the table is a flop array so every row can be cleared asynchronously; a RAM could not be.
   // NOTE: non-blocking assignments keep same-edge readers seeing the pre-update contents.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            btb_q[i] <= ROW_RESET;
         end
      end else if (wr_en) begin
         btb_q[upd_idx] <= row_d;
      end
   end

   assign mispredict  = upd_en && ((upd_taken != upd_pred_taken) ||
                        (upd_taken && upd_pred_taken && (upd_target != upd_pred_target)));
   assign redirect_pc = upd_taken ? upd_target : upd_pc + 32'd4;

endmodule
